// File: rtl/imem_loader_if.sv
// Host-pin and core-fetch signal bundle for the instruction memory loader.
// master = host/core side, slave = loader.
`timescale 1ns/1ps
interface imem_loader_if #(
    parameter int AW = 4
);
    logic          load_en;
    logic          byte_strb;
    logic [7:0]    byte_in;
    logic [AW-1:0] fetch_addr;
    logic [31:0]   fetch_instr;
    logic          core_run;
    logic [AW:0]   prog_len;
    logic          overflow;
    logic          busy;

    modport master (
        output load_en, byte_strb, byte_in, fetch_addr,
        input  fetch_instr, core_run, prog_len, overflow, busy
    );

    modport slave (
        input  load_en, byte_strb, byte_in, fetch_addr,
        output fetch_instr, core_run, prog_len, overflow, busy
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-wide program loader feeding a DEPTH-word instruction memory; holds the
// core stalled until a program has been loaded, then serves fetches combinationally.
`timescale 1ns/1ps
module imem_loader #(
    parameter int          DEPTH       = 16,
    parameter int          AW          = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave ldr
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LEN  = {{AW{1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] load_sync_q, strb_sync_q;
    logic                   strb_prev_q;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [23:0]            hold_q, hold_d;
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            prog_len_q, prog_len_d;
    logic                   overflow_q, overflow_d;
    logic [31:0]            mem_q [DEPTH];

    logic                   load_s;
    logic                   strb_s;
    logic                   strb_evt_s;
    logic                   full_s;
    logic                   mem_we_s;
    logic [31:0]            mem_wdata_s;
    logic                   fetch_hit_s;

    assign load_s     = load_sync_q[SYNC_STAGES-1];
    assign strb_s     = strb_sync_q[SYNC_STAGES-1];
    assign strb_evt_s = strb_s & ~strb_prev_q;
    assign full_s     = (prog_len_q == FULL_LEN);

    // Synchronise the asynchronous host pins and remember the last synced strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_sync_q <= '0;
            strb_sync_q <= '0;
            strb_prev_q <= 1'b0;
        end else begin
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], ldr.load_en};
            strb_sync_q <= {strb_sync_q[SYNC_STAGES-2:0], ldr.byte_strb};
            strb_prev_q <= strb_s;
        end
    end

    // Next-state logic: mode transitions plus little-endian word assembly.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        hold_d      = hold_q;
        wr_ptr_d    = wr_ptr_q;
        prog_len_d  = prog_len_q;
        overflow_d  = overflow_q;
        mem_we_s    = 1'b0;
        mem_wdata_s = {ldr.byte_in, hold_q};
        case (state_q)
            ST_IDLE: begin
                if (load_s) begin
                    state_d    = ST_LOAD;
                    byte_cnt_d = 2'd0;
                    hold_d     = 24'd0;
                    wr_ptr_d   = '0;
                    prog_len_d = '0;
                    overflow_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Leaving LOAD wins over a coincident strobe; partial words are dropped.
                if (!load_s) begin
                    state_d    = ST_RUN;
                    byte_cnt_d = 2'd0;
                end else if (strb_evt_s) begin
                    if (full_s) begin
                        overflow_d = 1'b1;
                    end else if (byte_cnt_q == 2'd3) begin
                        mem_we_s   = 1'b1;
                        wr_ptr_d   = wr_ptr_q + ONE_LEN;
                        prog_len_d = prog_len_q + ONE_LEN;
                        byte_cnt_d = 2'd0;
                    end else begin
                        hold_d[{byte_cnt_q, 3'b000} +: 8] = ldr.byte_in;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (load_s) begin
                    state_d    = ST_LOAD;
                    byte_cnt_d = 2'd0;
                    hold_d     = 24'd0;
                    wr_ptr_d   = '0;
                    prog_len_d = '0;
                    overflow_d = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and assembly registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 2'd0;
            hold_q     <= 24'd0;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            overflow_q <= overflow_d;
        end
    end

    // Instruction storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= mem_wdata_s;
        end
    end

    assign fetch_hit_s = (state_q == ST_RUN) && ({1'b0, ldr.fetch_addr} < prog_len_q);

    assign ldr.fetch_instr = fetch_hit_s ? mem_q[ldr.fetch_addr] : NOP_INSTR;
    assign ldr.core_run    = (state_q == ST_RUN);
    assign ldr.busy        = (state_q == ST_LOAD);
    assign ldr.prog_len    = prog_len_q;
    assign ldr.overflow    = overflow_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expectations from a
// byte-list reference model, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam int          SS    = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        bit          is_fetch;
        logic [AW-1:0] addr;
        logic [31:0] instr;
        int          len;
        bit          ovf;
        bit          run;
        bit          busy;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_loader_if #(.AW(AW)) ldr_bus ();

    imem_loader #(
        .DEPTH(DEPTH), .AW(AW), .SYNC_STAGES(SS), .NOP_INSTR(NOP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ldr  (ldr_bus)
    );

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sess[$];
    bit         in_load  = 1'b0;

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: compare whatever the stimulus expected this cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (mon_e.is_fetch) begin
                cmp($sformatf("%s fetch[%0d]", mon_e.tag, mon_e.addr), ldr_bus.fetch_instr, mon_e.instr);
            end else begin
                cmp({mon_e.tag, " core_run"}, {31'd0, ldr_bus.core_run}, {31'd0, mon_e.run});
                cmp({mon_e.tag, " busy"}, {31'd0, ldr_bus.busy}, {31'd0, mon_e.busy});
                cmp({mon_e.tag, " prog_len"}, {27'd0, ldr_bus.prog_len}, mon_e.len);
                cmp({mon_e.tag, " overflow"}, {31'd0, ldr_bus.overflow}, {31'd0, mon_e.ovf});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int model_len();
        int n;
        n = sess.size() / 4;
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    function automatic bit model_ovf();
        return sess.size() > 4 * DEPTH;
    endfunction

    function automatic logic [31:0] model_word(input int k);
        return {sess[4*k+3], sess[4*k+2], sess[4*k+1], sess[4*k]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input bit run, input bit busy, input int len, input bit ovf);
        exp_t e;
        @(posedge clk);
        #1;
        e.is_fetch = 1'b0; e.addr = '0; e.instr = 32'd0;
        e.len = len; e.ovf = ovf; e.run = run; e.busy = busy; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic chk_fetch(input string tag, input int addr, input logic [31:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        ldr_bus.fetch_addr = AW'(addr);
        e.is_fetch = 1'b1; e.addr = AW'(addr); e.instr = exp;
        e.len = 0; e.ovf = 1'b0; e.run = 1'b0; e.busy = 1'b0; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi);
        ldr_bus.byte_in = b;
        cyc(1);
        ldr_bus.byte_strb = 1'b1;
        cyc(hi);
        ldr_bus.byte_strb = 1'b0;
        cyc(4);
        if (in_load) sess.push_back(b);
    endtask

    task automatic begin_load();
        ldr_bus.load_en = 1'b1;
        cyc(SS + 4);
        in_load = 1'b1;
        sess.delete();
    endtask

    task automatic end_load();
        ldr_bus.load_en = 1'b0;
        cyc(SS + 4);
        in_load = 1'b0;
    endtask

    task automatic check_run(input string tag);
        chk_status(tag, 1'b1, 1'b0, model_len(), model_ovf());
        for (int a = 0; a < DEPTH; a++) begin
            chk_fetch(tag, a, (a < model_len()) ? model_word(a) : NOP);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ldr_bus.load_en = 1'b0;
        ldr_bus.byte_strb = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        in_load = 1'b0;
        sess.delete();
    endtask

    initial begin
        logic [7:0] tv[$];
        int         nb;

        rst_n = 1'b0;
        ldr_bus.load_en = 1'b0;
        ldr_bus.byte_strb = 1'b0;
        ldr_bus.byte_in = 8'd0;
        ldr_bus.fetch_addr = '0;
        do_reset();

        // 1: reset state
        chk_status("reset", 1'b0, 1'b0, 0, 1'b0);
        for (int a = 0; a < DEPTH; a++) chk_fetch("reset", a, NOP);

        // 2: single add instruction
        begin_load();
        tv = '{8'hB3, 8'h00, 8'h31, 8'h00};
        foreach (tv[i]) send_byte(tv[i], 3);
        end_load();
        chk_status("add", 1'b1, 1'b0, 1, 1'b0);
        chk_fetch("add", 0, 32'h0031_00B3);
        chk_fetch("add", 1, NOP);

        // 3: trailing partial word dropped
        begin_load();
        tv = '{8'hB3, 8'h80, 8'h31, 8'h40, 8'h11, 8'h22};
        foreach (tv[i]) send_byte(tv[i], 2);
        end_load();
        chk_fetch("partial", 0, 32'h4031_80B3);
        check_run("partial");

        // 4: overfill, fetch gated while loading
        begin_load();
        for (int k = 0; k < 17; k++) begin
            for (int j = 0; j < 4; j++) send_byte(8'(k), 1);
            if (k == 2) begin
                chk_status("fill-mid", 1'b0, 1'b1, 3, 1'b0);
                chk_fetch("fill-mid", 0, NOP);
            end
        end
        chk_status("fill-end", 1'b0, 1'b1, DEPTH, 1'b1);
        end_load();
        chk_fetch("fill", 15, 32'h0F0F_0F0F);
        check_run("fill");

        // 5: long strobe counts once; RUN strobes ignored
        begin_load();
        send_byte(8'hA5, 20);
        send_byte(8'h5A, 2);
        send_byte(8'h3C, 2);
        send_byte(8'hC3, 2);
        end_load();
        chk_fetch("longstrb", 0, 32'hC33C_5AA5);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 2);
        check_run("run-strb");

        // 6: reload from RUN, then reset mid-word
        begin_load();
        for (int i = 0; i < 12; i++) send_byte(8'($urandom), 2);
        end_load();
        check_run("three");
        ldr_bus.load_en = 1'b1;
        cyc(SS);
        chk_status("reload", 1'b0, 1'b1, 0, 1'b0);
        chk_fetch("reload", 0, NOP);
        cyc(3);
        in_load = 1'b1;
        sess.delete();
        send_byte(8'h77, 2);
        send_byte(8'h88, 2);
        do_reset();
        chk_status("midreset", 1'b0, 1'b0, 0, 1'b0);
        chk_fetch("midreset", 0, NOP);
        send_byte(8'hEE, 2);
        send_byte(8'hDD, 2);
        begin_load();
        tv = '{8'h01, 8'h23, 8'h45, 8'h67};
        foreach (tv[i]) send_byte(tv[i], 2);
        end_load();
        chk_fetch("postreset", 0, 32'h6745_2301);
        check_run("postreset");

        // Randomised sessions against the byte-list model
        for (int s = 0; s < 6; s++) begin
            begin_load();
            nb = (s == 0) ? 70 : $urandom_range(0, 72);
            for (int i = 0; i < nb; i++) send_byte(8'($urandom), $urandom_range(1, 6));
            chk_status($sformatf("rand%0d-load", s), 1'b0, 1'b1, model_len(), model_ovf());
            end_load();
            check_run($sformatf("rand%0d", s));
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) cyc(1);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
